mole_round_sequencer: RTL and testbench

//  Sequences one timed whack-a-mole round: picks a pseudo-random mole, holds it up for a fixed

---
 rtl/mole_round_sequencer.sv | 144 ++++++++++++++
 tb/tb_mole_round_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_sequencer.sv
// Whack-a-mole round sequencer: lights one pseudo-random mole at a time, times it with
// tick-enabled down-counters, and scores hits/misses until the round timer runs out.
module mole_round_sequencer #(
  parameter int          NUM_MOLES   = 8,
  parameter int          ROUND_TICKS = 30000,
  parameter int          UP_TICKS    = 800,
  parameter int          GAP_TICKS   = 300,
  parameter int          SCORE_BITS  = 8,
  parameter int          TIME_BITS   = 15,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic                  tick,
  input  logic [NUM_MOLES-1:0]  hit,
  output logic [NUM_MOLES-1:0]  mole_onehot,
  output logic [SCORE_BITS-1:0] score,
  output logic [SCORE_BITS-1:0] misses,
  output logic [TIME_BITS-1:0]  time_left,
  output logic                  round_active,
  output logic                  game_over
);

  localparam int IDX_W = $clog2(NUM_MOLES);
  localparam int UP_W  = $clog2(UP_TICKS + 1);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);

  localparam logic [UP_W-1:0]       UP_INIT   = UP_W'(UP_TICKS);
  localparam logic [GAP_W-1:0]      GAP_INIT  = GAP_W'(GAP_TICKS);
  localparam logic [TIME_BITS-1:0]  TIME_INIT = TIME_BITS'(ROUND_TICKS);
  localparam logic [SCORE_BITS-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_UP, S_GAP, S_DONE} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [IDX_W-1:0] last_idx;
  logic [UP_W-1:0]  up_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             lfsr_fb;
  logic [IDX_W-1:0] raw_idx;
  logic [IDX_W-1:0] spawn_idx;
  logic             hit_ok;
  logic             hit_any;
  logic             active;
  logic             round_end;

  function automatic logic [SCORE_BITS-1:0] sat_inc(input logic [SCORE_BITS-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_BITS'(1);
  endfunction

  // Never repeat the previous mole; NUM_MOLES is a power of two so the +1 wraps naturally.
  always_comb begin
    lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    raw_idx   = lfsr[IDX_W-1:0];
    spawn_idx = (raw_idx == last_idx) ? raw_idx + IDX_W'(1) : raw_idx;
    hit_ok    = |(hit & mole_onehot);
    hit_any   = |hit;
    active    = (state == S_SPAWN) || (state == S_UP) || (state == S_GAP);
    round_end = active && tick && (time_left == TIME_BITS'(1));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= S_IDLE;
      lfsr         <= LFSR_SEED;
      last_idx     <= '0;
      up_cnt       <= '0;
      gap_cnt      <= '0;
      mole_onehot  <= '0;
      score        <= '0;
      misses       <= '0;
      time_left    <= TIME_INIT;
      round_active <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      if (active && tick && (time_left != '0))
        time_left <= time_left - TIME_BITS'(1);

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            score        <= '0;
            misses       <= '0;
            time_left    <= TIME_INIT;
            game_over    <= 1'b0;
            round_active <= 1'b1;
            state        <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          mole_onehot <= NUM_MOLES'(1) << spawn_idx;
          last_idx    <= spawn_idx;
          up_cnt      <= UP_INIT;
          state       <= S_UP;
        end
        S_UP: begin
          if (tick && (up_cnt != '0))
            up_cnt <= up_cnt - UP_W'(1);
          if (hit_ok) begin
            score       <= sat_inc(score);
            mole_onehot <= '0;
            gap_cnt     <= GAP_INIT;
            state       <= S_GAP;
          end else if (hit_any) begin
            misses <= sat_inc(misses);
          end else if (tick && (up_cnt == UP_W'(1))) begin
            misses      <= sat_inc(misses);
            mole_onehot <= '0;
            gap_cnt     <= GAP_INIT;
            state       <= S_GAP;
          end
        end
        S_GAP: begin
          if (hit_any)
            misses <= sat_inc(misses);
          if (tick && (gap_cnt != '0))
            gap_cnt <= gap_cnt - GAP_W'(1);
          if (tick && (gap_cnt == GAP_W'(1)))
            state <= S_SPAWN;
        end
        default: state <= S_IDLE;
      endcase

      // End of round wins over any state move made above; scoring from this cycle stands.
      if (round_end) begin
        state        <= S_DONE;
        mole_onehot  <= '0;
        round_active <= 1'b0;
        game_over    <= 1'b1;
      end
    end
  end

  a_mole_onehot0: assert property (@(posedge clk) disable iff (arst) $onehot0(mole_onehot));
  a_score_sat: assert property (@(posedge clk) disable iff (arst)
    (score == SCORE_MAX && !start) |=> (score == SCORE_MAX));
  a_misses_sat: assert property (@(posedge clk) disable iff (arst)
    (misses == SCORE_MAX && !start) |=> (misses == SCORE_MAX));

endmodule

// File: tb/tb_mole_round_sequencer.sv
// Bench for mole_round_sequencer: a behavioural model predicts every output snapshot into a
// queue as stimulus is driven; each scenario task pops and compares after the clock edge.
module tb_mole_round_sequencer;
  localparam int NM = 4, RT = 20, UT = 3, GT = 2, SB = 2, TB = 5;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int S_IDLE = 0, S_SPAWN = 1, S_UP = 2, S_GAP = 3, S_DONE = 4;

  logic          clk = 1'b0;
  logic          arst, start, tick;
  logic [NM-1:0] hit;
  logic [NM-1:0] mole_onehot;
  logic [SB-1:0] score, misses;
  logic [TB-1:0] time_left;
  logic          round_active, game_over;

  always #5 clk = ~clk;

  mole_round_sequencer #(
    .NUM_MOLES(NM), .ROUND_TICKS(RT), .UP_TICKS(UT), .GAP_TICKS(GT),
    .SCORE_BITS(SB), .TIME_BITS(TB), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .arst(arst), .start(start), .tick(tick), .hit(hit),
    .mole_onehot(mole_onehot), .score(score), .misses(misses), .time_left(time_left),
    .round_active(round_active), .game_over(game_over)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [14:0] exp_q[$];

  int          m_state, m_mole, m_last, m_score, m_miss, m_time, m_up, m_gap;
  logic [15:0] m_lfsr;

  function automatic logic [NM-1:0] oh(input int i);
    return (i < 0) ? '0 : NM'(1 << i);
  endfunction

  function automatic int pick(input logic [15:0] l, input int last);
    int i;
    i = int'(l[1:0]);
    if (i == last) i = (i + 1) % NM;
    return i;
  endfunction

  function automatic int inc_sat(input int v);
    return (v >= 3) ? 3 : v + 1;
  endfunction

  function automatic logic [14:0] observed();
    return {mole_onehot, score, misses, time_left, round_active, game_over};
  endfunction

  function automatic logic [14:0] m_snap();
    logic act;
    act = (m_state == S_SPAWN) || (m_state == S_UP) || (m_state == S_GAP);
    return {oh(m_mole), 2'(m_score), 2'(m_miss), 5'(m_time), act, (m_state == S_DONE)};
  endfunction

  task automatic m_reset();
    m_state = S_IDLE; m_mole = -1; m_last = 0; m_score = 0; m_miss = 0;
    m_time = RT; m_up = 0; m_gap = 0; m_lfsr = SEED;
  endtask

  task automatic m_step(input logic st, input logic [NM-1:0] h);
    logic [15:0] l;
    int ns;
    l = m_lfsr;
    ns = m_state;
    m_lfsr = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    case (m_state)
      S_IDLE, S_DONE: if (st) begin
        m_score = 0; m_miss = 0; m_time = RT; ns = S_SPAWN;
      end
      S_SPAWN: begin
        m_mole = pick(l, m_last); m_last = m_mole; m_up = UT; ns = S_UP;
      end
      S_UP: begin
        if ((h & oh(m_mole)) != 0) begin
          m_score = inc_sat(m_score); m_mole = -1; m_gap = GT; ns = S_GAP;
        end else if (h != 0) begin
          m_miss = inc_sat(m_miss);
        end else if (m_up == 1) begin
          m_miss = inc_sat(m_miss); m_mole = -1; m_gap = GT; ns = S_GAP;
        end
        if (m_up > 0) m_up--;
      end
      S_GAP: begin
        if (h != 0) m_miss = inc_sat(m_miss);
        if (m_gap == 1) ns = S_SPAWN;
        if (m_gap > 0) m_gap--;
      end
      default: ;
    endcase
    if (m_state == S_SPAWN || m_state == S_UP || m_state == S_GAP) begin
      if (m_time == 1) begin ns = S_DONE; m_mole = -1; end
      if (m_time > 0) m_time--;
    end
    m_state = ns;
  endtask

  task automatic drive(input logic st, input logic [NM-1:0] h);
    start = st;
    hit   = h;
    m_step(st, h);
    exp_q.push_back(m_snap());
    @(posedge clk); #1;
    start = 1'b0;
    hit   = '0;
  endtask

  task automatic test_reset();
    logic [14:0] got, want, rst_val;
    rst_val = {4'b0, 2'b0, 2'b0, 5'd20, 1'b0, 1'b0};
    arst = 1'b1; start = 1'b0; tick = 1'b1; hit = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    got = observed();
    n_vec++;
    if (got !== rst_val) begin
      n_err++; $display("FAIL reset_values got=%h want=%h", got, rst_val);
    end
    exp_q.push_back(m_snap());
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++; $display("FAIL reset_model got=%h want=%h", got, want);
    end
    arst = 1'b0;
  endtask

  task automatic test_round_countdown();
    logic [14:0] got, want;
    for (int k = 0; k <= RT; k++) begin
      drive(k == 0, '0);
      want = exp_q.pop_front(); got = observed();
      n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL countdown_snap k=%0d got=%h want=%h", k, got, want);
      end
      n_vec++;
      if (time_left !== 5'(RT - k)) begin
        n_err++; $display("FAIL countdown_time k=%0d got=%0d want=%0d", k, time_left, RT - k);
      end
      if (k == 0) begin
        n_vec++;
        if (round_active !== 1'b1 || mole_onehot !== 4'b0) begin
          n_err++; $display("FAIL spawn_cycle ra=%b mole=%b want ra=1 mole=0000", round_active, mole_onehot);
        end
      end
      if (k == 1) begin
        n_vec++;
        if (!$onehot(mole_onehot)) begin
          n_err++; $display("FAIL mole_visible got=%b want one-hot", mole_onehot);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (mole_onehot !== 4'b0 || misses !== 2'd1) begin
          n_err++; $display("FAIL expiry mole=%b misses=%0d want mole=0000 misses=1", mole_onehot, misses);
        end
      end
    end
    n_vec++;
    if (game_over !== 1'b1 || round_active !== 1'b0 || misses !== 2'd3 || mole_onehot !== 4'b0) begin
      n_err++;
      $display("FAIL round_done go=%b ra=%b misses=%0d mole=%b want go=1 ra=0 misses=3 mole=0000",
               game_over, round_active, misses, mole_onehot);
    end
  endtask

  task automatic test_hit_and_final_tick();
    logic [14:0]   got, want;
    logic [NM-1:0] first, h;
    first = '0;
    for (int k = 0; k <= RT; k++) begin
      h = (k == 2 || k == RT) ? oh(m_mole) : '0;
      drive(k == 0, h);
      want = exp_q.pop_front(); got = observed();
      n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL hit_snap k=%0d got=%h want=%h", k, got, want);
      end
      if (k == 1) first = oh(m_mole);
      if (k == 2) begin
        n_vec++;
        if (score !== 2'd1 || mole_onehot !== 4'b0) begin
          n_err++; $display("FAIL correct_hit score=%0d mole=%b want score=1 mole=0000", score, mole_onehot);
        end
      end
      if (k == 5) begin
        n_vec++;
        if (!$onehot(mole_onehot) || mole_onehot === first) begin
          n_err++; $display("FAIL new_mole got=%b want one-hot and not %b", mole_onehot, first);
        end
      end
    end
    n_vec++;
    if (score !== 2'd2 || misses !== 2'd2 || game_over !== 1'b1 || mole_onehot !== 4'b0 || time_left !== 5'd0) begin
      n_err++;
      $display("FAIL final_tick_hit score=%0d misses=%0d go=%b mole=%b time=%0d want 2 2 1 0000 0",
               score, misses, game_over, mole_onehot, time_left);
    end
  endtask

  task automatic test_wrong_and_miss();
    logic [14:0]   got, want;
    logic [NM-1:0] lit, h;
    lit = '0;
    for (int k = 0; k <= 4; k++) begin
      h = (k == 2) ? ~oh(m_mole) : '0;
      drive(k == 0, h);
      want = exp_q.pop_front(); got = observed();
      n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL miss_snap k=%0d got=%h want=%h", k, got, want);
      end
      if (k == 1) lit = oh(m_mole);
      if (k == 2) begin
        n_vec++;
        if (misses !== 2'd1 || mole_onehot !== lit) begin
          n_err++; $display("FAIL wrong_hit misses=%0d mole=%b want misses=1 mole=%b", misses, mole_onehot, lit);
        end
      end
      if (k == 4) begin
        n_vec++;
        if (misses !== 2'd2 || mole_onehot !== 4'b0) begin
          n_err++; $display("FAIL late_expiry misses=%0d mole=%b want misses=2 mole=0000", misses, mole_onehot);
        end
      end
    end
  endtask

  task automatic test_saturate_and_ignored_start();
    logic [14:0] got, want;
    int k;
    k = 5;
    while (game_over !== 1'b1 && k < 40) begin
      drive(k == 10, 4'hF);
      want = exp_q.pop_front(); got = observed();
      n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL sat_snap k=%0d got=%h want=%h", k, got, want);
      end
      if (k == 10) begin
        n_vec++;
        if (time_left !== 5'd10 || round_active !== 1'b1) begin
          n_err++; $display("FAIL start_ignored time=%0d ra=%b want time=10 ra=1", time_left, round_active);
        end
      end
      k++;
    end
    n_vec++;
    if (game_over !== 1'b1) begin
      n_err++; $display("FAIL sat_timeout go=%b want 1 within budget", game_over);
    end
    n_vec++;
    if (score !== 2'd3 || misses !== 2'd3) begin
      n_err++; $display("FAIL saturation score=%0d misses=%0d want 3 3", score, misses);
    end
  endtask

  task automatic test_async_reset();
    logic [14:0] got, want, rst_val;
    rst_val = {4'b0, 2'b0, 2'b0, 5'd20, 1'b0, 1'b0};
    for (int k = 0; k <= 2; k++) begin
      drive(k == 0, (k == 2) ? ~oh(m_mole) : 4'b0);
      want = exp_q.pop_front(); got = observed();
      n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL pre_reset_snap k=%0d got=%h want=%h", k, got, want);
      end
    end
    #3;
    arst = 1'b1;
    #1;
    m_reset();
    got = observed();
    n_vec++;
    if (got !== rst_val) begin
      n_err++; $display("FAIL async_reset got=%h want=%h", got, rst_val);
    end
    @(posedge clk); #1;
    arst = 1'b0;
    for (int k = 0; k <= 1; k++) begin
      drive(k == 0, '0);
      want = exp_q.pop_front(); got = observed();
      n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL post_reset_snap k=%0d got=%h want=%h", k, got, want);
      end
    end
    n_vec++;
    if (round_active !== 1'b1 || !$onehot(mole_onehot) || time_left !== 5'd19 || score !== 2'd0 || misses !== 2'd0) begin
      n_err++;
      $display("FAIL fresh_round ra=%b mole=%b time=%0d score=%0d misses=%0d want 1 one-hot 19 0 0",
               round_active, mole_onehot, time_left, score, misses);
    end
  endtask

  initial begin
    test_reset();
    test_round_countdown();
    test_hit_and_final_tick();
    test_wrong_and_miss();
    test_saturate_and_ignored_start();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
